// File: rtl/resta_serial_ctrl.sv
// resta_serial_ctrl: bit-serial a-b using one full-subtractor cell over WIDTH cycles, LSB first.
// Optional signed-overflow output enabled by defining RESTA_SERIAL_OVF_EN.
module resta_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef RESTA_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;
  logic             state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa, sb, acc;
  logic             br, x, y, d, bo, last;
  // On the final edge the operand LSBs hold the original MSBs, so overflow needs no extra state.
  always_comb begin
    x    = sa[0];
    y    = sb[0];
    d    = x ^ y ^ br;
    bo   = (~x & y) | (~x & br) | (y & br);
    last = cnt == CW'(WIDTH - 1);
  end
  assign busy = state == SHIFT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      br     <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef RESTA_SERIAL_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sa    <= a;
          sb    <= b;
          br    <= 1'b0;
          cnt   <= '0;
          state <= SHIFT;
        end
      end else begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        acc <= {d, acc[WIDTH-1:1]};
        br  <= bo;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          state  <= IDLE;
          done   <= 1'b1;
          diff   <= {d, acc[WIDTH-1:1]};
          borrow <= bo;
`ifdef RESTA_SERIAL_OVF_EN
          ovf    <= (x ^ y) & (d ^ x);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_resta_serial_ctrl.sv
// tb_resta_serial_ctrl: directed checks of resta_serial_ctrl at WIDTH=8.
module tb_resta_serial_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, borrow;
  logic [7:0] diff;
`ifdef RESTA_SERIAL_OVF_EN
  logic       ovf;
`endif
  int total = 0;
  int passed = 0;
  int n, pulses;

  resta_serial_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
`ifdef RESTA_SERIAL_OVF_EN
    .ovf(ovf),
`endif
    .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb);
    int c;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(c);
    chk({tag, "_lat"}, c, 8);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow, eb);
  endtask

  initial begin
    // test 1: reset, then a single operation with cycle-by-cycle busy checks
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
`ifdef RESTA_SERIAL_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    a = 8'h35;
    b = 8'h12;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("t1_busy", busy, 1);
      chk("t1_nodone", done, 0);
      chk("t1_diff_hold", diff, 0);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_busy_low", busy, 0);
    chk("t1_diff", diff, 8'h23);
    chk("t1_borrow", borrow, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_diff_held", diff, 8'h23);
    // test 2: borrow cases
    run_op("t2a", 8'h12, 8'h35, 8'hDD, 1'b1);
    run_op("t2b", 8'h00, 8'h01, 8'hFF, 1'b1);
    // test 3: start ignored while busy, then back-to-back start in the done cycle
    a = 8'h50;
    b = 8'h20;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'h01;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("t3_lat", n, 5);
    chk("t3_diff", diff, 8'h30);
    a = 8'h09;
    b = 8'h04;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_b2b_busy", busy, 1);
    chk("t3_single_done", done, 0);
    wait_done(n);
    chk("t3_b2b_lat", n, 8);
    chk("t3_b2b_diff", diff, 8'h05);
    chk("t3_b2b_borrow", borrow, 0);
    // test 4: reset mid-operation
    tick();
    a = 8'hFF;
    b = 8'h0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_diff", diff, 0);
    chk("t4_borrow", borrow, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk("t4_no_done", pulses, 0);
    run_op("t4_next", 8'h0A, 8'h03, 8'h07, 1'b0);
`ifdef RESTA_SERIAL_OVF_EN
    // test 5: signed overflow
    run_op("t5a", 8'h80, 8'h01, 8'h7F, 1'b0);
    chk("t5a_ovf", ovf, 1);
    run_op("t5b", 8'h05, 8'h03, 8'h02, 1'b0);
    chk("t5b_ovf", ovf, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
